// File: rtl/pe_frame_loader.sv
// -----------------------------------------------------------------------------
// pe_frame_loader
//
// Frame-load controller for one PE tile column. Configuration words arrive on
// a valid/ready stream as header/data pairs. Each good pair is written to the
// tile's frame latches with a setup / strobe / hold sequence so that FrameData
// is stable around every FrameStrobe pulse.
//
// Header word: [31:16] sync (16'hFAB0), [8] parity bit, [4:0] frame index.
//
// Ports:
//   CLK          clock
//   RST          synchronous active-high reset
//   s_data       configuration word (header or data)
//   s_valid      s_data valid
//   s_ready      loader accepts a word this cycle (IDLE and DATA only)
//   err_clear    clears the sticky error flag (a new error in the same cycle wins)
//   FrameData    frame data to the latches; changes only on a good data accept
//   FrameStrobe  one-hot frame latch enable, high for STROBE_CYCLES cycles
//   busy         FSM is not in IDLE
//   frame_done   one-cycle pulse in HOLD for each completed frame
//   err          sticky protocol error (bad sync, index out of range, parity)
//   frame_count  completed frames since reset, saturating at 16'hFFFF
//
// Build option:
//   PE_FRAME_LOADER_PARITY_EN  when defined, the XOR of the data word must
//                              match header bit 8 or the frame is rejected.
//                              When undefined, header bit 8 is ignored.
// -----------------------------------------------------------------------------
module pe_frame_loader #(
  parameter int MaxFramesPerCol = 32,
  parameter int FrameBitsPerRow = 32,
  parameter int STROBE_CYCLES   = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [31:0]                s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       err_clear,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       err,
  output logic [15:0]                frame_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DATA   = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  localparam logic [15:0] SYNC_WORD   = 16'hFAB0;
  localparam logic [5:0]  IDX_LIMIT   = 6'(MaxFramesPerCol);
  localparam logic [15:0] STROBE_LAST = 16'(STROBE_CYCLES - 1);

  logic [2:0]                 state_q,  state_d;
  logic [4:0]                 idx_q,    idx_d;
  logic                       drop_q,   drop_d;
  logic [15:0]                cnt_q,    cnt_d;
  logic [FrameBitsPerRow-1:0] data_q,   data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic                       done_q,   done_d;
  logic                       err_q,    err_d;
  logic [15:0]                count_q,  count_d;

  logic                       accept;
  logic                       err_set;
  logic                       parity_err;
  logic [MaxFramesPerCol-1:0] idx_onehot;

  // s_ready is low during the reset cycle itself, not just after it.
  assign s_ready = !RST && ((state_q == S_IDLE) || (state_q == S_DATA));
  assign accept  = s_valid && s_ready;

  // Only indices below MaxFramesPerCol reach the strobe states, so the shift
  // never runs off the end of the vector.
  assign idx_onehot = {{(MaxFramesPerCol-1){1'b0}}, 1'b1} << idx_q;

`ifdef PE_FRAME_LOADER_PARITY_EN
  logic parity_q;

  // Header parity bit, captured with the header so it can be compared when
  // the data word arrives.
  always_ff @(posedge CLK) begin
    if (RST) begin
      parity_q <= 1'b0;
    end else if (accept && (state_q == S_IDLE)) begin
      parity_q <= s_data[8];
    end
  end

  assign parity_err = (^s_data[FrameBitsPerRow-1:0]) != parity_q;
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    drop_d   = drop_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    count_d  = count_q;
    strobe_d = '0;
    done_d   = 1'b0;
    err_set  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (s_data[31:16] != SYNC_WORD) begin
            // Bad sync: drop the word, do not expect a data word.
            err_set = 1'b1;
          end else begin
            idx_d   = s_data[4:0];
            drop_d  = {1'b0, s_data[4:0]} >= IDX_LIMIT;
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          if (drop_q || parity_err) begin
            // The data word is consumed but never reaches the latches.
            err_set = 1'b1;
            state_d = S_IDLE;
          end else begin
            data_d  = s_data[FrameBitsPerRow-1:0];
            state_d = S_SETUP;
          end
        end
      end

      S_SETUP: begin
        // Strobe is registered, so it is requested one cycle ahead.
        cnt_d    = '0;
        strobe_d = idx_onehot;
        state_d  = S_STROBE;
      end

      S_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          done_d  = 1'b1;
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          state_d = S_HOLD;
        end else begin
          cnt_d    = cnt_q + 16'd1;
          strobe_d = idx_onehot;
        end
      end

      S_HOLD: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new error in the same cycle as err_clear leaves err set.
    err_d = err_set ? 1'b1 : (err_clear ? 1'b0 : err_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      drop_q   <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  // Strobe and done come straight from flops so the latch enables are glitch-free.
  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign frame_done  = done_q;
  assign err         = err_q;
  assign frame_count = count_q;
  assign busy        = state_q != S_IDLE;

endmodule

// File: tb/tb_pe_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_pe_frame_loader
//
// Directed bench for pe_frame_loader. The main instance uses the default
// parameters; a second instance with MaxFramesPerCol=16 covers out-of-range
// frame indices. Frames expected at the latches are queued when their data
// word is driven and compared by a monitor when the strobe rises.
// -----------------------------------------------------------------------------
module tb_pe_frame_loader;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } frame_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic [31:0] s_data    = '0;
  logic        s_valid   = 1'b0;
  logic        err_clear = 1'b0;
  logic        s_ready;
  logic [31:0] FrameData;
  logic [31:0] FrameStrobe;
  logic        busy, frame_done, err;
  logic [15:0] frame_count;

  logic [31:0] s16_data    = '0;
  logic        s16_valid   = 1'b0;
  logic        s16_ready;
  logic [31:0] FrameData16;
  logic [15:0] FrameStrobe16;
  logic        busy16, frame_done16, err16;
  logic [15:0] frame_count16;

  int n_pass  = 0;
  int n_total = 0;

  frame_t exp_q[$];
  int     rise_q[$];
  int     cyc            = 0;
  int     done_cnt       = 0;
  int     strobe16_cyc   = 0;
  int     run_len        = 0;
  bit     abort_pending  = 1'b0;
  logic [31:0] prev_strobe = '0;
  logic [31:0] prev_data   = '0;

  always #5 CLK = ~CLK;

  pe_frame_loader u_dut (
    .CLK         (CLK),
    .RST         (RST),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .err_clear   (err_clear),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .frame_done  (frame_done),
    .err         (err),
    .frame_count (frame_count)
  );

  pe_frame_loader #(.MaxFramesPerCol(16)) u_dut16 (
    .CLK         (CLK),
    .RST         (RST),
    .s_data      (s16_data),
    .s_valid     (s16_valid),
    .s_ready     (s16_ready),
    .err_clear   (1'b0),
    .FrameData   (FrameData16),
    .FrameStrobe (FrameStrobe16),
    .busy        (busy16),
    .frame_done  (frame_done16),
    .err         (err16),
    .frame_count (frame_count16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input bit sel, input logic [31:0] w, input bit keep_valid);
    bit ok;
    ok = 1'b0;
    if (sel) begin s16_data = w; s16_valid = 1'b1; end
    else     begin s_data   = w; s_valid   = 1'b1; end
    for (int i = 0; i < 64 && !ok; i++) begin
      if ((sel ? s16_ready : s_ready) === 1'b1) ok = 1'b1;
      tick();
    end
    if (!keep_valid) begin
      if (sel) s16_valid = 1'b0;
      else     s_valid   = 1'b0;
    end
    check("word_accepted", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input bit sel);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 64 && !idle; i++) begin
      if ((sel ? busy16 : busy) === 1'b0) idle = 1'b1;
      else tick();
    end
    check("idle_reached", {31'b0, idle}, 32'd1);
  endtask

  task automatic push_frame(input logic [4:0] idx, input logic [31:0] data);
    frame_t f;
    f.idx  = idx;
    f.data = data;
    exp_q.push_back(f);
  endtask

  // Strobe monitor for the main instance: scoreboard pop on each rising strobe,
  // one-hot and data-stability checks, strobe width and frame_done on the fall.
  always @(negedge CLK) begin
    frame_t f;
    cyc++;
    if (frame_done === 1'b1) done_cnt++;
    if (FrameStrobe16 !== '0) strobe16_cyc++;
    if (FrameStrobe !== '0) begin
      check("strobe_onehot", {31'b0, $onehot(FrameStrobe)}, 32'd1);
      check("data_stable_strobe", FrameData, prev_data);
      if (prev_strobe === '0) begin
        rise_q.push_back(cyc);
        check("frame_pending", {31'b0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          f = exp_q.pop_front();
          check("strobe_index", FrameStrobe, 32'd1 << f.idx);
          check("frame_data", FrameData, f.data);
        end
      end
      run_len++;
    end else if (prev_strobe !== '0) begin
      if (abort_pending) begin
        check("no_done_after_reset", {31'b0, frame_done}, 32'd0);
        abort_pending = 1'b0;
      end else begin
        check("data_stable_hold", FrameData, prev_data);
        check("strobe_width", run_len, 32'd2);
        check("done_in_hold", {31'b0, frame_done}, 32'd1);
      end
      run_len = 0;
    end
    prev_strobe = FrameStrobe;
    prev_data   = FrameData;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done_base;
    int str_base;
    bit seen;
    logic [4:0]  b2b_idx [3];
    logic [31:0] b2b_dat [3];

    // ---- Reset state ----
    tick();
    check("rst_s_ready", {31'b0, s_ready}, 32'd0);
    check("rst_framedata", FrameData, 32'd0);
    check("rst_strobe", FrameStrobe, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, frame_done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_count", {16'b0, frame_count}, 32'd0);
    RST = 1'b0;
    tick();
    check("idle_s_ready", {31'b0, s_ready}, 32'd1);

    // ---- Single frame to index 3 ----
    done_base = done_cnt;
    send(1'b0, 32'hFAB00003, 1'b0);
    push_frame(5'd3, 32'hDEADBEEF);
    send(1'b0, 32'hDEADBEEF, 1'b0);
    check("setup_data", FrameData, 32'hDEADBEEF);
    check("setup_strobe", FrameStrobe, 32'd0);
    check("setup_busy", {31'b0, busy}, 32'd1);
    check("setup_s_ready", {31'b0, s_ready}, 32'd0);
    wait_idle(1'b0);
    check("single_count", {16'b0, frame_count}, 32'd1);
    check("single_err", {31'b0, err}, 32'd0);
    check("single_done_pulses", done_cnt - done_base, 32'd1);

    // ---- Bad sync, then a good pair to index 1 ----
    send(1'b0, 32'h12340005, 1'b0);
    check("badsync_err", {31'b0, err}, 32'd1);
    check("badsync_busy", {31'b0, busy}, 32'd0);
    check("badsync_s_ready", {31'b0, s_ready}, 32'd1);
    send(1'b0, 32'hFAB00001, 1'b0);
    push_frame(5'd1, 32'h0000BEEF);
    send(1'b0, 32'h0000BEEF, 1'b0);
    wait_idle(1'b0);
    check("after_badsync_count", {16'b0, frame_count}, 32'd2);
    check("err_sticky", {31'b0, err}, 32'd1);

    // ---- err_clear alone, then err_clear together with a new error ----
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("err_cleared", {31'b0, err}, 32'd0);
    err_clear = 1'b1;
    send(1'b0, 32'h00000000, 1'b0);
    err_clear = 1'b0;
    check("set_beats_clear", {31'b0, err}, 32'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("err_cleared_again", {31'b0, err}, 32'd0);

`ifdef PE_FRAME_LOADER_PARITY_EN
    // ---- Parity: matching pair completes, mismatching pair is rejected ----
    send(1'b0, 32'hFAB00102, 1'b0);
    push_frame(5'd2, 32'h00000001);
    send(1'b0, 32'h00000001, 1'b0);
    wait_idle(1'b0);
    check("parity_ok_count", {16'b0, frame_count}, 32'd3);
    check("parity_ok_err", {31'b0, err}, 32'd0);
    done_base = done_cnt;
    send(1'b0, 32'hFAB00002, 1'b0);
    err_clear = 1'b1;
    send(1'b0, 32'h00000001, 1'b0);
    err_clear = 1'b0;
    check("parity_bad_err", {31'b0, err}, 32'd1);
    check("parity_bad_busy", {31'b0, busy}, 32'd0);
    tick(); tick(); tick(); tick();
    check("parity_bad_count", {16'b0, frame_count}, 32'd3);
    check("parity_bad_no_done", done_cnt - done_base, 32'd0);
`else
    // ---- Header bit 8 is ignored without the parity build option ----
    send(1'b0, 32'hFAB00102, 1'b0);
    push_frame(5'd2, 32'h00000000);
    send(1'b0, 32'h00000000, 1'b0);
    wait_idle(1'b0);
    check("bit8_ignored_count", {16'b0, frame_count}, 32'd3);
    check("bit8_ignored_err", {31'b0, err}, 32'd0);
`endif

    // ---- Out-of-range index on the 16-frame instance ----
    send(1'b1, 32'hFAB00002, 1'b0);
    send(1'b1, 32'hA5A5A5A5, 1'b0);
    wait_idle(1'b1);
    check("c16_good_count", {16'b0, frame_count16}, 32'd1);
    check("c16_good_data", FrameData16, 32'hA5A5A5A5);
    check("c16_good_strobe_cycles", strobe16_cyc, 32'd2);
    str_base = strobe16_cyc;
    send(1'b1, 32'hFAB00012, 1'b0);
    check("c16_waits_data", {31'b0, busy16}, 32'd1);
    send(1'b1, 32'h00000001, 1'b0);
    check("c16_oor_err", {31'b0, err16}, 32'd1);
    check("c16_oor_busy", {31'b0, busy16}, 32'd0);
    check("c16_oor_data", FrameData16, 32'hA5A5A5A5);
    tick(); tick(); tick(); tick();
    check("c16_oor_count", {16'b0, frame_count16}, 32'd1);
    check("c16_oor_no_strobe", strobe16_cyc - str_base, 32'd0);

    // ---- Back-to-back pairs with s_valid held high ----
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    check("b2b_start_count", {16'b0, frame_count}, 32'd0);
    rise_q.delete();
    done_base  = done_cnt;
    b2b_idx[0] = 5'd0;  b2b_dat[0] = 32'h11111111;
    b2b_idx[1] = 5'd31; b2b_dat[1] = 32'h33333333;
    b2b_idx[2] = 5'd7;  b2b_dat[2] = 32'h77777777;
    for (int k = 0; k < 3; k++) begin
      send(1'b0, {16'hFAB0, 11'b0, b2b_idx[k]}, 1'b1);
      push_frame(b2b_idx[k], b2b_dat[k]);
      send(1'b0, b2b_dat[k], k < 2);
    end
    wait_idle(1'b0);
    check("b2b_strobes", rise_q.size(), 32'd3);
    if (rise_q.size() == 3) begin
      check("b2b_gap_0_1", rise_q[1] - rise_q[0], 32'd6);
      check("b2b_gap_1_2", rise_q[2] - rise_q[1], 32'd6);
    end
    check("b2b_count", {16'b0, frame_count}, 32'd3);
    check("b2b_done_pulses", done_cnt - done_base, 32'd3);
    check("b2b_queue_empty", exp_q.size(), 32'd0);

    // ---- Reset on the first strobe cycle ----
    send(1'b0, 32'hFAB00004, 1'b0);
    push_frame(5'd4, 32'hCAFEF00D);
    send(1'b0, 32'hCAFEF00D, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      if (FrameStrobe !== '0) seen = 1'b1;
      else tick();
    end
    check("strobe_reached", {31'b0, seen}, 32'd1);
    done_base     = done_cnt;
    abort_pending = 1'b1;
    RST           = 1'b1;
    tick();
    check("abort_strobe", FrameStrobe, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_count", {16'b0, frame_count}, 32'd0);
    check("abort_done", {31'b0, frame_done}, 32'd0);
    check("abort_s_ready", {31'b0, s_ready}, 32'd0);
    RST = 1'b0;
    tick(); tick(); tick();
    check("abort_no_done_pulse", done_cnt - done_base, 32'd0);
    check("abort_idle_ready", {31'b0, s_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
